atm_keypad_entry: RTL and testbench
===================================

ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 100, meaning idle cycles before a session is abandoned.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 The block SHALL have port key_valid, input, 1, a one-cycle strobe qualifying key_code.
REQ-005 The block SHALL have port key_code, input, 4: 0-9 digit, A ENTER, B CLEAR, C CANCEL, D LANG, E-F ignored.
REQ-006 The block SHALL have port req_ready, input, 1, from the downstream ATM stage, accepting the request.
REQ-007 The block SHALL have ports accNumber/12, pin/4, menuOption/3, amount/11, destinationAccNumber/12, all outputs, registered, holding committed field values.
REQ-008 The block SHALL have port lang, output, 1: 0 english, 1 arabic.
REQ-009 The block SHALL have outputs req_valid/1, err/1 (one-cycle pulse), timeout/1 (one-cycle pulse) and entry_state/3 (current state encoding).

Function
REQ-010 The FSM SHALL use states IDLE=0, ACC=1, PIN=2, MENU=3, AMT=4, DEST=5, REQ=6.
REQ-011 A digit in IDLE SHALL load the accumulator with that digit and move to ACC.
REQ-012 In ACC/PIN/MENU/AMT/DEST, a digit SHALL update acc = acc*10 + digit, unless the result exceeds the field limit or digit cap, in which case err pulses and acc is unchanged.
REQ-013 Field limits: ACC 4095 / 4 digits, PIN 15 / 2 digits, MENU 7 / 1 digit, AMT 2047 / 4 digits, DEST 4095 / 4 digits.
REQ-014 ENTER with zero digits entered SHALL pulse err and hold the state.
REQ-015 Otherwise ENTER SHALL commit acc to the state's output field, clear acc and the digit count, and advance: ACC->PIN, PIN->MENU.
REQ-016 ENTER in MENU with value 3 SHALL set amount=0 and go to REQ.
REQ-017 ENTER in MENU with value 4-7 SHALL go to AMT.
REQ-018 ENTER in MENU with value 0-2 SHALL pulse err, leave menuOption unchanged and hold MENU.
REQ-019 ENTER in AMT SHALL go to DEST when menuOption==6, else to REQ.
REQ-020 ENTER in DEST SHALL go to REQ.
REQ-021 CLEAR SHALL zero acc and the digit count without a state change.
REQ-022 CANCEL in any non-REQ state SHALL go to IDLE and zero all field outputs and acc.
REQ-023 LANG SHALL toggle lang in any state, including REQ.
REQ-024 req_valid SHALL be 1 exactly while in REQ, with fields stable.
REQ-025 When req_valid and req_ready are both high on a cycle, the FSM SHALL go to MENU on the next cycle; accNumber and pin are retained.
REQ-026 All keys except LANG SHALL be ignored in REQ.
REQ-027 Keys E/F SHALL be ignored in every state.
REQ-028 key_valid with no state-changing effect SHALL still count as activity for the timeout.

Reset
REQ-029 When rst_n=0 at a posedge, the state SHALL be IDLE.
REQ-030 When rst_n=0 at a posedge, all field outputs, acc, the digit count, lang, req_valid, err, timeout and the timeout counter SHALL be 0.
REQ-031 Reset mid-entry or mid-REQ SHALL abandon the session with no req_valid afterwards.

Configuration
REQ-032 With KEYPAD_TIMEOUT_EN defined, a counter SHALL clear on key_valid or in IDLE, and increment otherwise.
REQ-033 With KEYPAD_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 in ACC..DEST, the block SHALL pulse timeout and take the CANCEL action.
REQ-034 With KEYPAD_TIMEOUT_EN defined, the block SHALL never time out in REQ.
REQ-035 Without KEYPAD_TIMEOUT_EN, no counter SHALL exist and timeout SHALL be tied to 0.

Verification
REQ-036 Keys 2,8,1,6,A,6,A,3,A -> req_valid with accNumber=2816, pin=6, menuOption=3, amount=0; req_ready=1 -> entry_state=3.
REQ-037 From MENU: keys 7,A,4,3,0,A -> req_valid with menuOption=7, amount=430.
REQ-038 From MENU: keys 6,A,9,9,A,3,4,6,7,A, lang toggled via D -> req_valid with amount=99, destinationAccNumber=3467, lang=1.
REQ-039 In AMT: keys 2,0,4,8 -> err pulse on the 8, accumulator 204; then 9 -> err (4-digit cap not hit, 2049>2047).
REQ-040 With the macro defined: enter PIN state, no keys for 100 cycles -> timeout pulse, entry_state=0, accNumber=0.
REQ-041 rst_n=0 for one cycle while in REQ -> req_valid=0 next cycle, all outputs 0.

Source files
------------

// File: rtl/atm_keypad_entry.sv
// ATM keypad entry FSM: collects account, PIN, menu, amount and destination fields and issues a request.
// Optional idle timeout is enabled by defining KEYPAD_TIMEOUT_EN.
module atm_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        req_ready,
    output logic [11:0] accNumber,
    output logic [3:0]  pin,
    output logic [2:0]  menuOption,
    output logic [10:0] amount,
    output logic [11:0] destinationAccNumber,
    output logic        lang,
    output logic        req_valid,
    output logic        err,
    output logic        timeout,
    output logic [2:0]  entry_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ACC = 3'd1, S_PIN = 3'd2, S_MENU = 3'd3,
        S_AMT  = 3'd4, S_DEST = 3'd5, S_REQ = 3'd6
    } state_t;

    localparam logic [3:0] K_ENTER  = 4'hA;
    localparam logic [3:0] K_CLEAR  = 4'hB;
    localparam logic [3:0] K_CANCEL = 4'hC;
    localparam logic [3:0] K_LANG   = 4'hD;

    state_t      state, state_nx;
    logic [11:0] acc, acc_nx;
    logic [2:0]  dcnt, dcnt_nx;
    logic [11:0] acc_num_nx, dest_nx;
    logic [3:0]  pin_nx;
    logic [2:0]  menu_nx;
    logic [10:0] amount_nx;
    logic        lang_nx, err_nx, cancel;
    logic [15:0] acc_calc;
    logic [11:0] limit;
    logic [2:0]  cap;
    logic        tmo_hit;

`ifdef KEYPAD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tcnt;

    // The counter also rests in REQ so a return to MENU starts a fresh idle interval.
    assign tmo_hit = !key_valid && (state inside {S_ACC, S_PIN, S_MENU, S_AMT, S_DEST})
                     && (tcnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= tmo_hit;
            if (key_valid || state == S_IDLE || state == S_REQ) tcnt <= '0;
            else                                                 tcnt <= tcnt + CW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        limit = 12'd4095;
        cap   = 3'd4;
        case (state)
            S_PIN:   begin limit = 12'd15;   cap = 3'd2; end
            S_MENU:  begin limit = 12'd7;    cap = 3'd1; end
            S_AMT:   begin limit = 12'd2047; cap = 3'd4; end
            default: ;
        endcase
    end

    assign acc_calc = 16'(acc) * 16'd10 + 16'(key_code);

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        acc_nx     = acc;
        dcnt_nx    = dcnt;
        acc_num_nx = accNumber;
        pin_nx     = pin;
        menu_nx    = menuOption;
        amount_nx  = amount;
        dest_nx    = destinationAccNumber;
        lang_nx    = lang;
        err_nx     = 1'b0;
        cancel     = tmo_hit;

        if (!tmo_hit && key_valid) begin
            if (key_code == K_LANG) begin
                lang_nx = ~lang;
            end else if (state == S_REQ || key_code > K_LANG) begin
                // REQ only honours LANG; E/F are ignored everywhere.
            end else if (key_code <= 4'd9) begin
                if (state == S_IDLE) begin
                    acc_nx   = 12'(key_code);
                    dcnt_nx  = 3'd1;
                    state_nx = S_ACC;
                end else if (dcnt >= cap || acc_calc > 16'(limit)) begin
                    err_nx = 1'b1;
                end else begin
                    acc_nx  = acc_calc[11:0];
                    dcnt_nx = dcnt + 3'd1;
                end
            end else if (key_code == K_CLEAR) begin
                acc_nx  = '0;
                dcnt_nx = '0;
            end else if (key_code == K_CANCEL) begin
                cancel = 1'b1;
            end else if (key_code == K_ENTER) begin
                if (dcnt == 3'd0) begin
                    err_nx = 1'b1;
                end else begin
                    acc_nx  = '0;
                    dcnt_nx = '0;
                    case (state)
                        S_ACC: begin acc_num_nx = acc; state_nx = S_PIN; end
                        S_PIN: begin pin_nx = acc[3:0]; state_nx = S_MENU; end
                        S_MENU: begin
                            if (acc == 12'd3) begin
                                menu_nx   = 3'd3;
                                amount_nx = '0;
                                state_nx  = S_REQ;
                            end else if (acc >= 12'd4) begin
                                menu_nx  = acc[2:0];
                                state_nx = S_AMT;
                            end else begin
                                // Invalid menu choice: keep the typed value so it can be cleared.
                                acc_nx  = acc;
                                dcnt_nx = dcnt;
                                err_nx  = 1'b1;
                            end
                        end
                        S_AMT: begin
                            amount_nx = acc[10:0];
                            state_nx  = (menuOption == 3'd6) ? S_DEST : S_REQ;
                        end
                        S_DEST: begin dest_nx = acc; state_nx = S_REQ; end
                        default: ;
                    endcase
                end
            end
        end

        if (state == S_REQ && req_ready) state_nx = S_MENU;

        if (cancel) begin
            state_nx   = S_IDLE;
            acc_nx     = '0;
            dcnt_nx    = '0;
            acc_num_nx = '0;
            pin_nx     = '0;
            menu_nx    = '0;
            amount_nx  = '0;
            dest_nx    = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= S_IDLE;
            acc                  <= '0;
            dcnt                 <= '0;
            accNumber            <= '0;
            pin                  <= '0;
            menuOption           <= '0;
            amount               <= '0;
            destinationAccNumber <= '0;
            lang                 <= 1'b0;
            err                  <= 1'b0;
        end else begin
            state                <= state_nx;
            acc                  <= acc_nx;
            dcnt                 <= dcnt_nx;
            accNumber            <= acc_num_nx;
            pin                  <= pin_nx;
            menuOption           <= menu_nx;
            amount               <= amount_nx;
            destinationAccNumber <= dest_nx;
            lang                 <= lang_nx;
            err                  <= err_nx;
        end
    end

    assign req_valid   = (state == S_REQ);
    assign entry_state = state;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Self-checking bench for atm_keypad_entry: directed key sequences with a request scoreboard.
// Covers both builds; the timeout section adapts to KEYPAD_TIMEOUT_EN.
module tb_atm_keypad_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        req_ready;
    logic [11:0] accNumber;
    logic [3:0]  pin;
    logic [2:0]  menuOption;
    logic [10:0] amount;
    logic [11:0] destinationAccNumber;
    logic        lang;
    logic        req_valid;
    logic        err;
    logic        timeout;
    logic [2:0]  entry_state;

    typedef struct {
        logic [11:0] acc;
        logic [3:0]  pin;
        logic [2:0]  menu;
        logic [10:0] amount;
        logic [11:0] dest;
        logic        lang;
    } req_t;

    req_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    atm_keypad_entry #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .req_ready(req_ready), .accNumber(accNumber), .pin(pin), .menuOption(menuOption),
        .amount(amount), .destinationAccNumber(destinationAccNumber), .lang(lang),
        .req_valid(req_valid), .err(err), .timeout(timeout), .entry_state(entry_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press_str(input string s);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c >= 8'h41) press(4'(c - 8'h41 + 8'd10));
            else            press(4'(c - 8'h30));
        end
    endtask

    task automatic push_req(input logic [11:0] a, input logic [3:0] p, input logic [2:0] m,
                            input logic [10:0] amt, input logic [11:0] d, input logic l);
        req_t r;
        r.acc = a; r.pin = p; r.menu = m; r.amount = amt; r.dest = d; r.lang = l;
        exp_q.push_back(r);
    endtask

    task automatic wait_req(input string tag);
        req_t r;
        int   seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_valid === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_req_valid"}, 32'(seen), 32'd1);
        if (seen != 0) begin
            check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check({tag, "_accNumber"}, 32'(accNumber), 32'(r.acc));
                check({tag, "_pin"}, 32'(pin), 32'(r.pin));
                check({tag, "_menu"}, 32'(menuOption), 32'(r.menu));
                check({tag, "_amount"}, 32'(amount), 32'(r.amount));
                check({tag, "_dest"}, 32'(destinationAccNumber), 32'(r.dest));
                check({tag, "_lang"}, 32'(lang), 32'(r.lang));
            end
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check({tag, "_state_menu"}, 32'(entry_state), 32'd3);
        check({tag, "_req_dropped"}, 32'(req_valid), 32'd0);
    endtask

    initial begin
        int tmo_at;
        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; req_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(entry_state), 32'd0);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_fields", 32'(accNumber | 12'(pin) | 12'(menuOption) | 12'(amount)
                                | destinationAccNumber), 32'd0);
        check("rst_lang", 32'(lang), 32'd0);
        rst_n = 1'b1;

        // Balance enquiry path.
        push_req(12'd2816, 4'd6, 3'd3, 11'd0, 12'd0, 1'b0);
        press_str("2816A");
        check("acc_to_pin", 32'(entry_state), 32'd2);
        press_str("6A3A");
        wait_req("bal");
        press(4'h5);
        check("req_ignores_digit", 32'(entry_state), 32'd6);
        handshake("bal");
        check("bal_acc_retained", 32'(accNumber), 32'd2816);

        // Withdrawal: menu 7, amount 430.
        push_req(12'd2816, 4'd6, 3'd7, 11'd430, 12'd0, 1'b0);
        press_str("7A");
        check("menu_to_amt", 32'(entry_state), 32'd4);
        press_str("430A");
        wait_req("wd");
        handshake("wd");

        // Transfer with language toggle mid-entry.
        push_req(12'd2816, 4'd6, 3'd6, 11'd99, 12'd3467, 1'b1);
        press_str("6AD");
        check("lang_toggled", 32'(lang), 32'd1);
        press_str("99A");
        check("amt_to_dest", 32'(entry_state), 32'd5);
        press_str("3467A");
        wait_req("xfer");
        press(4'hD);
        check("lang_in_req", 32'(lang), 32'd0);
        check("lang_keeps_req", 32'(entry_state), 32'd6);
        handshake("xfer");

        // Invalid menu choice, then amount limit handling.
        press_str("2A");
        check("menu_bad_err", 32'(err), 32'd1);
        check("menu_bad_hold", 32'(entry_state), 32'd3);
        check("menu_bad_keep", 32'(menuOption), 32'd6);
        press_str("B5A");
        check("menu5_amt", 32'(entry_state), 32'd4);
        press_str("204");
        check("amt_204_noerr", 32'(err), 32'd0);
        press(4'h8);
        check("amt_2048_err", 32'(err), 32'd1);
        press(4'h9);
        check("amt_2049_err", 32'(err), 32'd1);
        push_req(12'd2816, 4'd6, 3'd5, 11'd204, 12'd3467, 1'b0);
        press(4'hA);
        wait_req("amt");
        handshake("amt");

        // Empty ENTER and ignored E key.
        press(4'hA);
        check("empty_enter_err", 32'(err), 32'd1);
        check("empty_enter_hold", 32'(entry_state), 32'd3);
        press(4'hE);
        check("key_e_noerr", 32'(err), 32'd0);
        check("key_e_hold", 32'(entry_state), 32'd3);

        // Cancel mid-amount.
        press_str("4A1C");
        check("cancel_state", 32'(entry_state), 32'd0);
        check("cancel_fields", 32'(accNumber | 12'(pin) | 12'(menuOption) | 12'(amount)
                                   | destinationAccNumber), 32'd0);

        // Idle in PIN.
        press_str("12A");
        check("pin_entered", 32'(entry_state), 32'd2);
        tmo_at = 0;
        for (int i = 1; i <= 130; i++) begin
            @(negedge clk);
            if (timeout === 1'b1 && tmo_at == 0) tmo_at = i;
        end
`ifdef KEYPAD_TIMEOUT_EN
        check("timeout_cycle", 32'(tmo_at), 32'd100);
        check("timeout_state", 32'(entry_state), 32'd0);
        check("timeout_acc", 32'(accNumber), 32'd0);
`else
        check("no_timeout", 32'(tmo_at), 32'd0);
        check("no_timeout_state", 32'(entry_state), 32'd2);
`endif
        press(4'hC);

        // Account and PIN field limits.
        press_str("409");
        press(4'h6);
        check("acc_4096_err", 32'(err), 32'd1);
        press(4'h5);
        check("acc_4095_ok", 32'(err), 32'd0);
        press_str("A1");
        press(4'h6);
        check("pin_16_err", 32'(err), 32'd1);
        press_str("5A");
        check("pin_15_accnum", 32'(accNumber), 32'd4095);
        check("pin_15_pin", 32'(pin), 32'd15);

        // Reset while a request is pending.
        press_str("3AD");
        check("pre_rst_req", 32'(req_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_req_drop", 32'(req_valid), 32'd0);
        check("rst_req_state", 32'(entry_state), 32'd0);
        check("rst_req_fields", 32'(accNumber | 12'(pin) | 12'(menuOption) | 12'(amount)
                                    | destinationAccNumber), 32'd0);
        check("rst_req_lang", 32'(lang), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_req_stays_low", 32'(req_valid), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
